// File: rtl/multicycle_fsm.sv
// multicycle_fsm: per-state control sequencer for the multicycle RV64 datapath.
// Optional build macro FSM_ILLEGAL_TRAP_EN parks illegal opcodes in TRAP until reset.
module multicycle_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCwrite,
  output logic       Irwrite,
  output logic       Regwrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_AUIPC    = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q;
  state_t     state_d;
  state_t     dec_s;
  logic [2:0] alu_fn;
  logic       branch_take;

  // While rst is high the outputs show FETCH values with all strobes off.
  assign dec_s = rst ? S_FETCH : state_q;
  assign state = state_q;

  // ALU operation for EXECR/EXECI; only register-register funct3 000 can subtract.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (dec_s == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b010:  alu_fn = ALU_SLT;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // beq takes on zero, bne on !zero, other branch kinds never redirect.
  always_comb begin
    branch_take = 1'b0;
    case (funct3)
      3'b000:  branch_take = zero;
      3'b001:  branch_take = ~zero;
      default: branch_take = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_ADDI:      state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_B:         state_d = S_BRANCH;
          OP_AUIPC:     state_d = S_AUIPC;
`ifdef FSM_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SD) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_AUIPC:    state_d = S_ALUWB;
`ifdef FSM_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`else
      S_TRAP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath control decode.
  always_comb begin
    PCwrite    = 1'b0;
    Irwrite    = 1'b0;
    Regwrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    case (dec_s)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        Irwrite   = mem_ready;
        PCwrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_SD) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        Regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUControl = alu_fn;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = alu_fn;
      end
      S_ALUWB: begin
        Regwrite = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_SUB;
        PCwrite    = branch_take;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: begin
      end
    endcase
    if (rst) begin
      PCwrite  = 1'b0;
      Irwrite  = 1'b0;
      Regwrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  // State register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
`ifdef FSM_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef FSM_ILLEGAL_TRAP_EN
      illegal <= (state_d == S_TRAP);
`endif
    end
  end

`ifndef FSM_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule
